// File: rtl/instr_encoder_if.sv
// Bundle of the instruction encoder's field-set input and encoded-word output
// handshakes. The master modport is the side that supplies field sets and
// consumes encoded words; the slave modport is the encoder itself.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [5:0]  rd;
  logic [5:0]  rs;
  logic [5:0]  rt;
  logic [31:0] imm;
  logic        use_imm;
  logic        immSignal;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [7:0]  addr;
  logic        err_range;
  logic [7:0]  err_count;

  modport master (
    output in_valid, opcode, rd, rs, rt, imm, use_imm, immSignal, out_ready,
    input  in_ready, out_valid, instr, addr, err_range, err_count
  );

  modport slave (
    input  in_valid, opcode, rd, rs, rt, imm, use_imm, immSignal, out_ready,
    output in_ready, out_valid, instr, addr, err_range, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: packs opcode/register/immediate fields into a 32-bit
// word, emits it through a one-entry output stage with valid/ready handshake
// and tags each word with an 8-bit wrapping word address.
// Optional feature: define INSTR_ENC_RANGE_CHECK_EN to drop (and count) words
// whose immediate does not fit the selected immediate width.
module instr_encoder (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  instr_encoder_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        range_ok_s;
  logic        load_s;
  logic [31:0] word_s;
  logic [31:0] instr_r;
  logic [7:0]  addr_r;
  logic [7:0]  ptr_r;

  // Field packing; unused fields of each form are ignored.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  op,
    input logic [5:0]  f_rd,
    input logic [5:0]  f_rs,
    input logic [5:0]  f_rt,
    input logic [31:0] f_imm,
    input logic        f_use_imm,
    input logic        f_short
  );
    logic [31:0] w;
    if (!f_use_imm) begin
      w = {op, f_rd, f_rs, f_rt, 10'b0};
    end else if (f_short) begin
      w = {op, f_rd, f_rs, f_imm[5:0], 10'b0};
    end else begin
      w = {op, f_rd, f_imm[11:0], 10'b0};
    end
    return w;
  endfunction

  // Encode the currently presented field set.
  always_comb begin
    word_s = encode_word(bus.opcode, bus.rd, bus.rs, bus.rt, bus.imm,
                         bus.use_imm, bus.immSignal);
  end

  // Accept whenever the stage is empty or draining this cycle; never during
  // reset or clear.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst_n && !clr && (state_r == EMPTY || bus.out_ready)) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s = bus.in_valid && in_ready_s;
  assign load_s   = accept_s && range_ok_s;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic       drop_s;
  logic       err_range_r;
  logic [7:0] err_count_r;

  // A signed immediate fits when all bits above the field's sign bit copy it.
  function automatic logic imm_fits(input logic [31:0] v, input logic f_short);
    logic ok;
    if (f_short) begin
      ok = (v[31:5] == {27{1'b0}}) || (v[31:5] == {27{1'b1}});
    end else begin
      ok = (v[31:11] == {21{1'b0}}) || (v[31:11] == {21{1'b1}});
    end
    return ok;
  endfunction

  // Register-form words carry no immediate and always pass.
  always_comb begin
    range_ok_s = 1'b1;
    if (bus.use_imm) begin
      range_ok_s = imm_fits(bus.imm, bus.immSignal);
    end else begin
      range_ok_s = 1'b1;
    end
  end

  assign drop_s = accept_s && !range_ok_s;

  // Sticky range flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_range_r <= 1'b0;
      err_count_r <= 8'd0;
    end else if (clr) begin
      err_range_r <= 1'b0;
      err_count_r <= 8'd0;
    end else if (drop_s) begin
      err_range_r <= 1'b1;
      err_count_r <= (err_count_r == 8'd255) ? 8'd255 : err_count_r + 8'd1;
    end else begin
      err_range_r <= err_range_r;
      err_count_r <= err_count_r;
    end
  end

  assign bus.err_range = err_range_r;
  assign bus.err_count = err_count_r;
`else
  logic imm_unused_s;

  assign range_ok_s   = 1'b1;
  assign imm_unused_s = ^bus.imm[31:12];
  assign bus.err_range = 1'b0;
  assign bus.err_count = 8'd0;
`endif

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output stage next state; clear wins over every other event.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY:   state_nxt_s = load_s ? FULL : EMPTY;
        FULL: begin
          if (load_s) begin
            state_nxt_s = FULL;
          end else if (bus.out_ready) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: state_nxt_s = EMPTY;
      endcase
    end
  end

  // Output word, its address and the write pointer; only a loaded word
  // advances the pointer, so held words stay stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= 32'd0;
      addr_r  <= 8'd0;
      ptr_r   <= 8'd0;
    end else if (clr) begin
      instr_r <= 32'd0;
      addr_r  <= 8'd0;
      ptr_r   <= 8'd0;
    end else if (load_s) begin
      instr_r <= word_s;
      addr_r  <= ptr_r;
      ptr_r   <= ptr_r + 8'd1;
    end else begin
      instr_r <= instr_r;
      addr_r  <= addr_r;
      ptr_r   <= ptr_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == FULL);
  assign bus.instr     = instr_r;
  assign bus.addr      = addr_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: fixed encode vectors, backpressure,
// mid-transfer reset, clear, address wrap and randomized traffic against a
// queue-based reference model.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  instr_encoder_if bus();

  instr_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  addr;
  } word_t;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  rd;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [31:0] imm;
    logic        ui;
    logic        is;
    logic [31:0] exp;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  word_t q[$];
  int    m_ptr = 0;
  bit    m_err = 1'b0;
  int    m_cnt = 0;
  bit    acc_flag = 1'b0;
  vec_t  tbl[6];

  // Reference encoding from plain field arithmetic.
  function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [5:0] rd,
      input logic [5:0] rs, input logic [5:0] rt, input logic [31:0] imm,
      input logic ui, input logic is);
    logic [31:0] r;
    r = 32'(op) * 32'h1000_0000 + 32'(rd) * 32'h0040_0000;
    if (!ui)
      r = r + 32'(rs) * 32'h0001_0000 + 32'(rt) * 32'h0000_0400;
    else if (is)
      r = r + 32'(rs) * 32'h0001_0000 + (imm % 32'd64) * 32'h0000_0400;
    else
      r = r + (imm % 32'd4096) * 32'h0000_0400;
    return r;
  endfunction

  function automatic bit ref_in_range(input logic [31:0] imm, input logic is);
    int v;
    v = $signed(imm);
    return is ? (v >= -32 && v <= 31) : (v >= -2048 && v <= 2047);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ptr = 0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("instr", bus.instr, q[0].instr);
      check("addr", 32'(bus.addr), 32'(q[0].addr));
    end
    check("err_range", 32'(bus.err_range), 32'(m_err));
    check("err_count", 32'(bus.err_count), 32'(m_cnt));
  endtask

  // Called just after a negedge with inputs driven; runs one clock edge.
  task automatic cycle();
    bit    exp_valid;
    bit    exp_ready;
    bit    keep;
    word_t w;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = !clr && (!exp_valid || bus.out_ready);
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    acc_flag = bus.in_valid && exp_ready;
    if (clr) begin
      model_clear();
    end else begin
      if (exp_valid && bus.out_ready) void'(q.pop_front());
      if (acc_flag) begin
        keep = 1'b1;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        if (bus.use_imm && !ref_in_range(bus.imm, bus.immSignal)) begin
          keep  = 1'b0;
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
`endif
        if (keep) begin
          w.instr = ref_encode(bus.opcode, bus.rd, bus.rs, bus.rt, bus.imm,
                               bus.use_imm, bus.immSignal);
          w.addr  = 8'(m_ptr);
          q.push_back(w);
          m_ptr = (m_ptr + 1) % 256;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_word(input logic [3:0] op, input logic [5:0] rd, input logic [5:0] rs,
      input logic [5:0] rt, input logic [31:0] imm, input logic ui, input logic is);
    bus.opcode = op; bus.rd = rd; bus.rs = rs; bus.rt = rt;
    bus.imm = imm; bus.use_imm = ui; bus.immSignal = is;
  endtask

  task automatic rand_fields();
    logic [31:0] imm;
    if ($urandom_range(0, 3) == 0) imm = $urandom;
    else imm = 32'($urandom_range(0, 63)) - 32'd32;
    set_word(4'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), imm,
             1'($urandom), 1'($urandom));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_addr"}, 32'(bus.addr), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_err_range"}, 32'(bus.err_range), 32'd0);
    check({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
  endtask

  // Assert reset between edges; returns just after a negedge with reset released.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("rst_mid");
    model_clear();
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    logic [7:0] last_addr;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_word(4'd0, 6'd0, 6'd0, 6'd0, 32'd0, 1'b0, 1'b0);

    tbl[0] = '{4'h1, 6'd3,    6'd5,    6'd7,    32'h0000_0000, 1'b0, 1'b0, 32'h10C5_1C00};
    tbl[1] = '{4'hE, 6'd2,    6'h3F,   6'h2A,   32'hFFFF_FFFF, 1'b1, 1'b0, 32'hE0BF_FC00};
    tbl[2] = '{4'h3, 6'h3F,   6'h01,   6'h15,   32'hFFFF_FFE0, 1'b1, 1'b1, 32'h3FC1_8000};
    tbl[3] = '{4'hF, 6'h00,   6'h3F,   6'h3F,   32'h0001_2345, 1'b0, 1'b1, 32'hF03F_FC00};
    tbl[4] = '{4'h5, 6'h15,   6'h00,   6'h00,   32'h0000_07FF, 1'b1, 1'b0, 32'h555F_FC00};
    tbl[5] = '{4'h8, 6'h01,   6'h2A,   6'h00,   32'h0000_001F, 1'b1, 1'b1, 32'h806A_7C00};

    // Power-on reset state.
    #1;
    reset_checks("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Nothing emitted in the first cycle after release.
    bus.in_valid = 1'b0;
    cycle();

    // Fixed encode vectors, one word per cycle.
    for (int i = 0; i < 6; i++) begin
      set_word(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].imm, tbl[i].ui, tbl[i].is);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      cycle();
      check($sformatf("tbl%0d_instr", i), bus.instr, tbl[i].exp);
      check($sformatf("tbl%0d_addr", i), 32'(bus.addr), 32'(i));
    end
    bus.in_valid = 1'b0;
    cycle();

    // Clear with a pending input: not accepted, address restarts.
    clr = 1'b1;
    bus.in_valid = 1'b1;
    cycle();
    clr = 1'b0;

    // Backpressure: three words, output stalled for four cycles.
    k = 0;
    for (int n = 0; n < 20 && k < 3; n++) begin
      set_word(4'(k + 2), 6'(k + 10), 6'(k + 20), 6'(k + 30), 32'd0, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.out_ready = (n >= 5);
      cycle();
      if (acc_flag) k++;
    end
    check("bp_words_accepted", 32'(k), 32'd3);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    cycle();

    // Reset while a word is held.
    set_word(4'h9, 6'd1, 6'd2, 6'd3, 32'd0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    cycle();
    do_reset();
    bus.out_ready = 1'b1;
    cycle();

    // Address wrap over 257 streamed words.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    last_addr = 8'hAA;
    for (int n = 0; n < 257; n++) begin
      rand_fields();
      bus.use_imm = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      cycle();
      if (n == 255) check("wrap_addr255", 32'(bus.addr), 32'd255);
      last_addr = bus.addr;
    end
    check("wrap_addr_after", 32'(last_addr), 32'd0);
    check("wrap_no_err", 32'(bus.err_range), 32'd0);
    bus.in_valid = 1'b0;
    cycle();

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // Out-of-range short immediate is dropped and counted.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    set_word(4'h1, 6'd1, 6'd1, 6'd0, 32'd32, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    cycle();
    check("range_out_valid", 32'(bus.out_valid), 32'd0);
    check("range_err", 32'(bus.err_range), 32'd1);
    check("range_cnt", 32'(bus.err_count), 32'd1);
    set_word(4'h1, 6'd1, 6'd1, 6'd0, 32'd31, 1'b1, 1'b1);
    cycle();
    check("range_next_addr", 32'(bus.addr), 32'd0);
    bus.in_valid = 1'b0;
    cycle();
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rand_fields();
      bus.in_valid = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      cycle();
    end
    clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: clr  input  1  synchronous clear of address, errors and output stage.
REQ-004 SHALL have: in_valid  input  1  field set valid; in_ready  output  1  encoder can accept.
REQ-005 SHALL have: opcode  input  4; rd  input  6; rs  input  6; rt  input  6; all are register/op fields.
REQ-006 SHALL have: imm  input  32  signed immediate; use_imm  input  1  immediate form.
REQ-007 SHALL have: immSignal  input  1  1 = short 6-bit immediate, 0 = long 12-bit immediate.
REQ-008 SHALL have: out_valid  output  1; out_ready  input  1; instr  output  32  encoded word.
REQ-009 SHALL have: addr  output  8  word address of instr; err_range  output  1  sticky; err_count  output  8.

Function
REQ-010 SHALL encode use_imm=0 as {opcode, rd, rs, rt, 10'b0}.
REQ-011 SHALL encode use_imm=1, immSignal=1 as {opcode, rd, rs, imm[5:0], 10'b0}.
REQ-012 SHALL encode use_imm=1, immSignal=0 as {opcode, rd, imm[11:0], 10'b0}.
REQ-013 SHALL accept input on a cycle with in_valid && in_ready; 1-cycle latency to out_valid.
REQ-014 SHALL drive in_ready = !clr && (!out_valid || out_ready), so back-to-back transfers sustain one word per cycle.
REQ-015 SHALL hold instr, addr and out_valid stable while out_valid && !out_ready.
REQ-016 SHALL advance an internal write pointer by 1 on each emitted word; addr shows the pointer value captured with the word.
REQ-017 SHALL wrap the pointer from 255 to 0 without flagging an error.
REQ-018 SHALL treat the output stage as a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 SHALL move EMPTY->FULL on accept, FULL->EMPTY on out_ready without accept, and stay FULL on simultaneous drain and accept.
REQ-020 SHALL, when clr=1, go to EMPTY, zero pointer, err_range and err_count, and not accept input; clr overrides all events that cycle.
REQ-021 SHALL ignore rt when use_imm=1, and ignore imm and immSignal when use_imm=0.

Reset
REQ-022 SHALL on rst_n=0 immediately force out_valid=0, instr=0, addr=0, pointer=0, err_range=0, err_count=0.
REQ-023 SHALL discard any word held in FULL when reset asserts mid-transfer; no word SHALL be emitted in the first cycle after release.
REQ-024 SHALL drive in_ready=0 while rst_n=0.

Configuration
REQ-025 SHALL compile the immediate range check only when INSTR_ENC_RANGE_CHECK_EN is defined.
REQ-026 With the macro defined, the check SHALL fail when imm lies outside -32..31 (short form) or -2048..2047 (long form).
REQ-027 With the macro defined, a failing word SHALL be accepted but dropped, with no emit and no pointer advance.
REQ-028 With the macro defined, a failing word SHALL set err_range, and err_count SHALL increment and saturate at 255.
REQ-029 Without the macro, the immediate SHALL be truncated silently, err_range and err_count SHALL be tied to 0, and every accepted word SHALL be emitted.

Verification
REQ-030 Register-form encode: opcode=1, rd=3, rs=5, rt=7, use_imm=0 -> instr=0x10C51C00, addr=0, one cycle later.
REQ-031 Long-form encode: opcode=0xE, rd=2, imm=-1, use_imm=1, immSignal=0 -> instr=0xE0BFFC00.
REQ-032 Range drop (macro on): short form, imm=32 -> no out_valid, err_range=1, err_count=1, next good word addr unchanged.
REQ-033 Backpressure: 3 back-to-back words with out_ready low for 4 cycles -> instr held stable, in_ready=0, all 3 words emitted in order with addr 0,1,2.
REQ-034 Wrap: 257 words streamed -> addr 255 followed by 0 then 0... sequence continues, no error.
REQ-035 Mid-transfer reset and clr: rst_n pulsed while FULL -> out_valid=0 at once; clr with in_valid=1 -> in_ready=0 and addr restarts at 0.
